// File: rtl/iqmode.sv
// Issue-policy selector shared by every issue queue instance.
package iqmode;

  typedef enum logic {
    in_order,
    ooo
  } iq_mode_t;

endpackage

// File: rtl/issue_queue_pkg.sv
// Shared micro-op and queue-entry types for the issue queue.
package issue_queue_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  // Decoded micro-op as delivered by rename; tag identifies it downstream.
  typedef struct packed {
    logic [7:0] tag;
    reg_idx_t   rd;
    logic       has_rs1;
    reg_idx_t   rs1;
    logic       has_rs2;
    reg_idx_t   rs2;
  } queue_item_t;

  // One queue slot: payload plus per-operand readiness.
  typedef struct packed {
    queue_item_t item;
    logic        rs1_rdy;
    logic        rs2_rdy;
  } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// Find-first-set over a request vector: lowest index wins.
module iq_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         req,
  output logic [DEPTH-1:0]         gnt,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     any
);

  localparam int IDX_W = $clog2(DEPTH);

  // Scan from the top so the last (lowest) hit overwrites earlier ones.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see
    // earlier results within the same evaluation.
    gnt = '0;
    idx = '0;
    any = |req;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Age-ordered collapsing issue queue. Slot 0 is the oldest entry.
// MODE selects head-only (in_order) or oldest-ready-first (ooo) issue.
// Optional macro ISSUE_QUEUE_BYPASS_EN: an empty queue may issue lane 0
// in the same cycle it is enqueued.
module issue_queue
  import iqmode::*;
  import issue_queue_pkg::*;
#(
  parameter int       DEPTH = 8,
  parameter int       ENQ_W = 2,
  parameter int       WB_W  = 2,
  parameter iq_mode_t MODE  = ooo,
  localparam int      CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [ENQ_W-1:0]             enq_valid,
  output logic                         enq_ready,
  input  queue_item_t [ENQ_W-1:0]      enq_item,
  input  logic [ENQ_W-1:0]             enq_rs1_rdy,
  input  logic [ENQ_W-1:0]             enq_rs2_rdy,
  input  logic [WB_W-1:0]              wb_valid,
  input  logic [WB_W-1:0][REG_W-1:0]   wb_rd,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output queue_item_t                  iss_item,
  output logic [CNT_W-1:0]             count
);

  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t          entries     [DEPTH];
  iq_entry_t          nxt_entries [DEPTH];
  iq_entry_t          lane_ent    [ENQ_W];
  logic [DEPTH-1:0]   rdy_vec;
  logic [DEPTH-1:0]   req;
  logic [DEPTH-1:0]   sel_gnt;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic               q_fire;
  logic               byp_take;
  logic [CNT_W-1:0]   nxt_count;
`ifdef ISSUE_QUEUE_BYPASS_EN
  logic               byp_valid;
`endif

  // True when some writeback port broadcasts register r this cycle; x0 never wakes.
  function automatic logic wb_hit(input reg_idx_t r);
    wb_hit = 1'b0;
    for (int j = 0; j < WB_W; j++) begin
      if (wb_valid[j] && (wb_rd[j] == r) && (r != '0)) wb_hit = 1'b1;
    end
  endfunction

  // Space for a full group of lanes, judged on registered occupancy only.
  assign enq_ready = (count <= CNT_W'(DEPTH - ENQ_W));

  // Ready vector over occupied slots; in_order only lets the head compete.
  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = (CNT_W'(i) < count) & entries[i].rs1_rdy & entries[i].rs2_rdy;
    end
    req = (MODE == in_order) ? (rdy_vec & DEPTH'(1)) : rdy_vec;
  end

  iq_select #(.DEPTH(DEPTH)) u_select (
    .req (req),
    .gnt (sel_gnt),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Build incoming entries, resolving operand readiness including same-cycle wakeup.
  always_comb begin
    for (int l = 0; l < ENQ_W; l++) begin
      lane_ent[l].item    = enq_item[l];
      lane_ent[l].rs1_rdy = !enq_item[l].has_rs1 || (enq_item[l].rs1 == '0) ||
                            enq_rs1_rdy[l] || wb_hit(enq_item[l].rs1);
      lane_ent[l].rs2_rdy = !enq_item[l].has_rs2 || (enq_item[l].rs2 == '0) ||
                            enq_rs2_rdy[l] || wb_hit(enq_item[l].rs2);
    end
  end

  // Issue port: combinational from registered state, suppressed under flush.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch.
    q_fire = sel_any & ~flush & iss_ready;
`ifdef ISSUE_QUEUE_BYPASS_EN
    byp_valid = (count == '0) & ~flush & enq_valid[0] &
                lane_ent[0].rs1_rdy & lane_ent[0].rs2_rdy;
    iss_valid = (sel_any & ~flush) | byp_valid;
    iss_item  = byp_valid ? enq_item[0] : entries[sel_idx].item;
    byp_take  = byp_valid & iss_ready;
`else
    iss_valid = sel_any & ~flush;
    iss_item  = entries[sel_idx].item;
    byp_take  = 1'b0;
`endif
  end

  // Collapse out the issued slot, apply wakeups, then append enqueued lanes.
  always_comb begin
    iq_entry_t        up   [DEPTH];
    iq_entry_t        src;
    logic [CNT_W-1:0] pos  [ENQ_W];
    logic [ENQ_W-1:0] lane_en;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] n_enq;
    logic             seen;

    for (int i = 0; i < DEPTH - 1; i++) up[i] = entries[i+1];
    up[DEPTH-1] = '0;

    lane_en    = enq_valid & {ENQ_W{enq_ready}};
    lane_en[0] = lane_en[0] & ~byp_take;

    base  = count - CNT_W'(q_fire);
    n_enq = '0;
    for (int l = 0; l < ENQ_W; l++) begin
      pos[l] = base + n_enq;
      n_enq  = n_enq + CNT_W'(lane_en[l]);
    end

    seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      seen = seen | sel_gnt[i];
      src  = (q_fire && seen) ? up[i] : entries[i];
      src.rs1_rdy = src.rs1_rdy | wb_hit(src.item.rs1);
      src.rs2_rdy = src.rs2_rdy | wb_hit(src.item.rs2);
      for (int l = 0; l < ENQ_W; l++) begin
        if (lane_en[l] && (pos[l] == CNT_W'(i))) src = lane_ent[l];
      end
      nxt_entries[i] = src;
    end

    nxt_count = flush ? '0 : (base + n_enq);
  end

  // Occupancy register; it alone defines which slots are live.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from pre-edge values.
    if (!rst_n) count <= '0;
    else        count <= nxt_count;
  end

  // Slot storage follows the occupancy register.
  always_ff @(posedge clk) begin
    // NOTE: the slot array is deliberately left unreset; count == 0 marks
    // every slot dead, so clearing the payload would only add reset fanout.
    entries <= nxt_entries;
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: one in_order and one ooo instance share
// stimulus; a queue-based model is compared on every falling edge, and
// hand-computed literals pin the key timing points.
module tb_issue_queue;
  import iqmode::*;
  import issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int ENQ_W = 2;
  localparam int WB_W  = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                       clk;
  logic                       rst_n;
  logic                       flush;
  logic [ENQ_W-1:0]           enq_valid;
  queue_item_t [ENQ_W-1:0]    enq_item;
  logic [ENQ_W-1:0]           enq_rs1_rdy;
  logic [ENQ_W-1:0]           enq_rs2_rdy;
  logic [WB_W-1:0]            wb_valid;
  logic [WB_W-1:0][REG_W-1:0] wb_rd;
  logic                       iss_ready;

  // Index 0: in_order instance, index 1: ooo instance.
  logic                       enq_ready_m [2];
  logic                       iss_valid_m [2];
  queue_item_t                iss_item_m  [2];
  logic [CNT_W-1:0]           count_m     [2];

  int tests = 0;
  int fails = 0;

  issue_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .WB_W(WB_W), .MODE(in_order)) u_ino (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready_m[0]), .enq_item(enq_item),
    .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .iss_valid(iss_valid_m[0]), .iss_ready(iss_ready), .iss_item(iss_item_m[0]),
    .count(count_m[0])
  );

  issue_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .WB_W(WB_W), .MODE(ooo)) u_ooo (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready_m[1]), .enq_item(enq_item),
    .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .iss_valid(iss_valid_m[1]), .iss_ready(iss_ready), .iss_item(iss_item_m[1]),
    .count(count_m[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    queue_item_t item;
    bit          r1;
    bit          r2;
  } m_ent_t;

  m_ent_t mq [2][$];

  function automatic bit hit(input reg_idx_t r);
    hit = 1'b0;
    for (int j = 0; j < WB_W; j++) if (wb_valid[j] && wb_rd[j] == r && r != 0) hit = 1'b1;
  endfunction

  // Compare DUT outputs against the model mid-cycle, then advance the model
  // with the inputs the DUT will see at the next rising edge.
  always @(negedge clk) begin
    int sel;
    int n;
    bit ev;
    m_ent_t e;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        mq[m].delete();
        check($sformatf("m%0d rst count", m), 64'(count_m[m]), 64'(0));
        check($sformatf("m%0d rst iss_valid", m), 64'(iss_valid_m[m]), 64'(0));
        check($sformatf("m%0d rst enq_ready", m), 64'(enq_ready_m[m]), 64'(1));
      end else begin
        n   = mq[m].size();
        sel = -1;
        for (int k = 0; k < n; k++) begin
          if (sel < 0 && mq[m][k].r1 && mq[m][k].r2 && (m == 1 || k == 0)) sel = k;
        end
        ev = (sel >= 0) && !flush;
        check($sformatf("m%0d count", m), 64'(count_m[m]), 64'(n));
        check($sformatf("m%0d enq_ready", m), 64'(enq_ready_m[m]), 64'(n <= DEPTH - ENQ_W));
        check($sformatf("m%0d iss_valid", m), 64'(iss_valid_m[m]), 64'(ev));
        if (ev) check($sformatf("m%0d iss_item", m), 64'(iss_item_m[m]), 64'(mq[m][sel].item));
        if (enq_valid != '0 && n > DEPTH - ENQ_W) begin
          fails++;
          $display("FAIL m%0d protocol: enqueue %b while not ready at count %0d", m, enq_valid, n);
        end
        if (flush) begin
          mq[m].delete();
        end else begin
          if (ev && iss_ready) mq[m].delete(sel);
          for (int k = 0; k < mq[m].size(); k++) begin
            if (hit(mq[m][k].item.rs1)) mq[m][k].r1 = 1'b1;
            if (hit(mq[m][k].item.rs2)) mq[m][k].r2 = 1'b1;
          end
          if (n <= DEPTH - ENQ_W) begin
            for (int l = 0; l < ENQ_W; l++) begin
              if (enq_valid[l]) begin
                e.item = enq_item[l];
                e.r1 = !enq_item[l].has_rs1 || enq_item[l].rs1 == 0 || enq_rs1_rdy[l] || hit(enq_item[l].rs1);
                e.r2 = !enq_item[l].has_rs2 || enq_item[l].rs2 == 0 || enq_rs2_rdy[l] || hit(enq_item[l].rs2);
                mq[m].push_back(e);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic queue_item_t mk(input logic [7:0] tag, input logic [4:0] rd,
                                     input logic h1, input logic [4:0] r1,
                                     input logic h2, input logic [4:0] r2);
    queue_item_t it;
    it.tag = tag; it.rd = rd;
    it.has_rs1 = h1; it.rs1 = r1;
    it.has_rs2 = h2; it.rs2 = r2;
    return it;
  endfunction

  task automatic idle();
    flush       = 1'b0;
    enq_valid   = '0;
    enq_rs1_rdy = '0;
    enq_rs2_rdy = '0;
    wb_valid    = '0;
  endtask

  // Advance one cycle; inputs return to idle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_iss(input int m, input logic v, input logic [7:0] tag);
    check($sformatf("lit m%0d iss_valid", m), 64'(iss_valid_m[m]), 64'(v));
    if (v) check($sformatf("lit m%0d tag", m), 64'(iss_item_m[m].tag), 64'(tag));
  endtask

  task automatic expect_cnt(input int m, input int c, input logic rdy);
    check($sformatf("lit m%0d count", m), 64'(count_m[m]), 64'(c));
    check($sformatf("lit m%0d enq_ready", m), 64'(enq_ready_m[m]), 64'(rdy));
  endtask

  initial begin
    rst_n     = 1'b0;
    iss_ready = 1'b0;
    enq_item  = '0;
    wb_rd     = '0;
    idle();
    repeat (2) tick();
    #1;
    for (int m = 0; m < 2; m++) begin
      expect_cnt(m, 0, 1'b1);
      expect_iss(m, 1'b0, 8'd0);
    end
    rst_n = 1'b1;
    tick();

    // Ready chain: addi ready at once, add waits on x1 and x3.
    iss_ready   = 1'b1;
    enq_valid   = 2'b11;
    enq_item[0] = mk(8'd1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0);
    enq_item[1] = mk(8'd2, 5'd2, 1'b1, 5'd1, 1'b1, 5'd3);
    tick(); #1;
    expect_iss(1, 1'b1, 8'd1);
    expect_iss(0, 1'b1, 8'd1);
    tick(); #1;
    expect_cnt(1, 1, 1'b1);
    expect_iss(1, 1'b0, 8'd0);
    tick();
    tick();
    wb_valid = 2'b11; wb_rd[0] = 5'd1; wb_rd[1] = 5'd3;
    #1;
    expect_iss(1, 1'b0, 8'd0);
    tick(); #1;
    expect_iss(1, 1'b1, 8'd2);
    expect_iss(0, 1'b1, 8'd2);
    tick(); #1;
    expect_cnt(0, 0, 1'b1);
    expect_cnt(1, 0, 1'b1);

    // Mode contrast: head blocked on x5, younger entry ready.
    enq_valid   = 2'b11;
    enq_item[0] = mk(8'd3, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0);
    enq_item[1] = mk(8'd4, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(); #1;
    expect_iss(1, 1'b1, 8'd4);
    expect_iss(0, 1'b0, 8'd0);
    tick(); #1;
    expect_cnt(1, 1, 1'b1);
    expect_cnt(0, 2, 1'b1);
    wb_valid = 2'b01; wb_rd[0] = 5'd5;
    #1;
    expect_iss(0, 1'b0, 8'd0);
    tick(); #1;
    expect_iss(0, 1'b1, 8'd3);
    expect_iss(1, 1'b1, 8'd3);
    tick(); #1;
    expect_iss(0, 1'b1, 8'd4);
    expect_cnt(1, 0, 1'b1);
    tick(); #1;
    expect_cnt(0, 0, 1'b1);

    // Same-cycle wakeup at enqueue.
    enq_valid   = 2'b01;
    enq_item[0] = mk(8'd5, 5'd8, 1'b1, 5'd7, 1'b0, 5'd0);
    wb_valid    = 2'b10; wb_rd[1] = 5'd7;
    tick(); #1;
    expect_iss(0, 1'b1, 8'd5);
    expect_iss(1, 1'b1, 8'd5);
    tick();

    // x0 source is always ready; a writeback to x0 wakes nothing.
    enq_valid   = 2'b01;
    enq_item[0] = mk(8'd6, 5'd9, 1'b1, 5'd0, 1'b1, 5'd10);
    tick(); #1;
    expect_iss(1, 1'b0, 8'd0);
    wb_valid = 2'b01; wb_rd[0] = 5'd0;
    tick(); #1;
    expect_iss(1, 1'b0, 8'd0);
    expect_iss(0, 1'b0, 8'd0);
    wb_valid = 2'b01; wb_rd[0] = 5'd10;
    tick(); #1;
    expect_iss(1, 1'b1, 8'd6);
    tick();

    // Occupancy limits with issue held off.
    iss_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      enq_valid   = 2'b11;
      enq_item[0] = mk(8'(10 + 2 * p), 5'd11, 1'b0, 5'd0, 1'b0, 5'd0);
      enq_item[1] = mk(8'(11 + 2 * p), 5'd12, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
    end
    #1;
    expect_cnt(0, 8, 1'b0);
    expect_cnt(1, 8, 1'b0);
    expect_iss(1, 1'b1, 8'd10);
    iss_ready = 1'b1;
    tick(); #1;
    expect_cnt(1, 7, 1'b0);
    tick(); #1;
    expect_cnt(1, 6, 1'b1);
    // Issue and enqueue together.
    enq_valid   = 2'b11;
    enq_item[0] = mk(8'd30, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0);
    enq_item[1] = mk(8'd31, 5'd14, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(); #1;
    expect_cnt(0, 7, 1'b0);
    expect_cnt(1, 7, 1'b0);
    tick();
    tick(); #1;
    expect_cnt(1, 5, 1'b1);

    // Flush beats a same-cycle enqueue and issue.
    flush       = 1'b1;
    enq_valid   = 2'b11;
    enq_item[0] = mk(8'd40, 5'd15, 1'b0, 5'd0, 1'b0, 5'd0);
    enq_item[1] = mk(8'd41, 5'd16, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    expect_iss(0, 1'b0, 8'd0);
    expect_iss(1, 1'b0, 8'd0);
    tick(); #1;
    expect_cnt(0, 0, 1'b1);
    expect_cnt(1, 0, 1'b1);

    // Backpressure: head held stable for three cycles.
    iss_ready   = 1'b0;
    enq_valid   = 2'b11;
    enq_item[0] = mk(8'd50, 5'd17, 1'b0, 5'd0, 1'b0, 5'd0);
    enq_item[1] = mk(8'd51, 5'd18, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    repeat (3) begin
      #1;
      expect_iss(0, 1'b1, 8'd50);
      expect_cnt(0, 2, 1'b1);
      tick();
    end

    // Asynchronous reset in the middle of traffic.
    iss_ready   = 1'b1;
    enq_valid   = 2'b11;
    enq_item[0] = mk(8'd52, 5'd19, 1'b0, 5'd0, 1'b0, 5'd0);
    enq_item[1] = mk(8'd53, 5'd20, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      expect_cnt(m, 0, 1'b1);
      expect_iss(m, 1'b0, 8'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    // Recovery after reset.
    enq_valid   = 2'b01;
    enq_item[0] = mk(8'd60, 5'd21, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(); #1;
    expect_iss(0, 1'b1, 8'd60);
    expect_iss(1, 1'b1, 8'd60);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
